alarm_ringer: RTL and testbench

//  Alarm output stage of the digital clock; sits directly downstream of the alarm value matcher.

---
 rtl/clock_pkg.sv | 15 +
 rtl/alarm_beep_gen.sv | 51 +++++
 rtl/alarm_ringer.sv | 152 +++++++++++++++
 tb/tb_alarm_ringer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and default timings for the digital clock alarm path.
package clock_pkg;

    typedef enum logic [1:0] {
        AL_IDLE   = 2'd0,
        AL_RING   = 2'd1,
        AL_SNOOZE = 2'd2
    } alarm_state_e;

    localparam int RING_TIMEOUT_S_DEF   = 60;
    localparam int SNOOZE_S_DEF         = 300;
    localparam int BEEP_HALF_CYCLES_DEF = 1000;
    localparam int MAX_SNOOZE_DEF       = 3;

endpackage

// File: rtl/alarm_beep_gen.sv
// Square-wave buzzer generator: starts high on restart, toggles every
// BEEP_HALF_CYCLES clocks while enabled, held low otherwise.
module alarm_beep_gen
    import clock_pkg::*;
#(
    parameter int BEEP_HALF_CYCLES = BEEP_HALF_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic buzzer
);

    localparam int CW = $clog2(BEEP_HALF_CYCLES + 1);
    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_HALF_CYCLES - 1);

    logic [CW-1:0] beep_cnt_q, beep_cnt_d;
    logic          buzzer_q, buzzer_d;

    // en/restart describe the next state, so the buzzer lines up with ringing.
    always_comb begin
        beep_cnt_d = beep_cnt_q;
        buzzer_d   = buzzer_q;
        if (!en) begin
            beep_cnt_d = '0;
            buzzer_d   = 1'b0;
        end else if (restart) begin
            beep_cnt_d = '0;
            buzzer_d   = 1'b1;
        end else if (beep_cnt_q == BEEP_LAST) begin
            beep_cnt_d = '0;
            buzzer_d   = ~buzzer_q;
        end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign buzzer = buzzer_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ring / snooze / timeout sequencer driven by the alarm matcher.
// Optional per-event snooze limit: define ALARM_SNOOZE_LIMIT_EN.
module alarm_ringer
    import clock_pkg::*;
#(
    parameter int RING_TIMEOUT_S   = RING_TIMEOUT_S_DEF,
    parameter int SNOOZE_S         = SNOOZE_S_DEF,
    parameter int BEEP_HALF_CYCLES = BEEP_HALF_CYCLES_DEF,
    parameter int MAX_SNOOZE       = MAX_SNOOZE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1hz,
    input  logic match,
    input  logic armed,
    input  logic snooze,
    input  logic dismiss,
    output logic buzzer,
    output logic ringing,
    output logic snoozing,
    output logic missed
);

    localparam int RW = $clog2(RING_TIMEOUT_S + 1);
    localparam int SW = $clog2(SNOOZE_S + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_S - 1);

    alarm_state_e  state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          match_d_q;
    logic          missed_q, missed_d;
    logic          ringing_q, snoozing_q;
    logic          trig;
    logic          snooze_ok;
    logic          beep_en, beep_restart;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int UW = $clog2(MAX_SNOOZE + 1);
    localparam logic [UW-1:0] USED_MAX = UW'(MAX_SNOOZE);
    logic [UW-1:0] snooze_used_q, snooze_used_d;

    assign snooze_ok = (snooze_used_q != USED_MAX);
`else
    // Unlimited snoozes; the OR keeps this constant regardless of MAX_SNOOZE.
    assign snooze_ok = 1'b1 | (MAX_SNOOZE == 0);
`endif

    // Rising edge of the level match starts at most one event per minute.
    assign trig = match & ~match_d_q & armed;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        missed_d   = missed_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snooze_used_d = snooze_used_q;
`endif
        if (dismiss) begin
            missed_d = 1'b0;
        end
        case (state_q)
            AL_IDLE: begin
                if (trig && !dismiss) begin
                    state_d    = AL_RING;
                    ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snooze_used_d = '0;
`endif
                end
            end
            AL_RING: begin
                if (!armed || dismiss) begin
                    state_d = AL_IDLE;
                end else if (snooze && snooze_ok) begin
                    state_d   = AL_SNOOZE;
                    snz_cnt_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snooze_used_d = snooze_used_q + 1'b1;
`endif
                end else if (tick_1hz) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d  = AL_IDLE;
                        missed_d = 1'b1;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                    end
                end
            end
            AL_SNOOZE: begin
                if (!armed || dismiss) begin
                    state_d = AL_IDLE;
                end else if (tick_1hz) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = AL_RING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = AL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AL_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            match_d_q  <= 1'b0;
            missed_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snooze_used_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            match_d_q  <= match;
            missed_q   <= missed_d;
            ringing_q  <= (state_d == AL_RING);
            snoozing_q <= (state_d == AL_SNOOZE);
`ifdef ALARM_SNOOZE_LIMIT_EN
            snooze_used_q <= snooze_used_d;
`endif
        end
    end

    // Any entry into RING (from IDLE or SNOOZE) restarts the beep high.
    assign beep_en      = (state_d == AL_RING);
    assign beep_restart = beep_en && (state_q != AL_RING);

    alarm_beep_gen #(
        .BEEP_HALF_CYCLES(BEEP_HALF_CYCLES)
    ) u_beep (
        .clk    (clk),
        .rst    (rst),
        .en     (beep_en),
        .restart(beep_restart),
        .buzzer (buzzer)
    );

    assign ringing  = ringing_q;
    assign snoozing = snoozing_q;
    assign missed   = missed_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed plus random checks of alarm_ringer against a behavioural model.
module tb_alarm_ringer;

    localparam int RT   = 4;
    localparam int SZ   = 3;
    localparam int HALF = 2;
    localparam int MAXS = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 1'b0, match = 1'b0, armed = 1'b1, snooze = 1'b0, dismiss = 1'b0;
    logic buzzer, ringing, snoozing, missed;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 idle, 1 ring, 2 snooze.
    int m_mode = 0, m_ring_s = 0, m_snz_s = 0, m_used = 0, m_beep_cyc = 0;
    bit m_missed = 0, m_match_prev = 0;

    alarm_ringer #(
        .RING_TIMEOUT_S  (RT),
        .SNOOZE_S        (SZ),
        .BEEP_HALF_CYCLES(HALF),
        .MAX_SNOOZE      (MAXS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_1hz(tick_1hz),
        .match   (match),
        .armed   (armed),
        .snooze  (snooze),
        .dismiss (dismiss),
        .buzzer  (buzzer),
        .ringing (ringing),
        .snoozing(snoozing),
        .missed  (missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit snooze_allowed();
`ifdef ALARM_SNOOZE_LIMIT_EN
        return m_used < MAXS;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        bit trig;
        int prev_mode;
        if (rst) begin
            m_mode = 0; m_ring_s = 0; m_snz_s = 0; m_used = 0; m_beep_cyc = 0;
            m_missed = 0; m_match_prev = 0;
            return;
        end
        trig = match && !m_match_prev && armed;
        prev_mode = m_mode;
        if (dismiss) m_missed = 0;
        if (m_mode == 0) begin
            if (trig && !dismiss) begin
                m_mode = 1; m_ring_s = 0; m_used = 0;
            end
        end else if (!armed || dismiss) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (snooze && snooze_allowed()) begin
                m_mode = 2; m_snz_s = 0; m_used++;
            end else if (tick_1hz) begin
                if (m_ring_s == RT - 1) begin
                    m_mode = 0; m_missed = 1;
                end else begin
                    m_ring_s++;
                end
            end
        end else if (tick_1hz) begin
            if (m_snz_s == SZ - 1) begin
                m_mode = 1; m_ring_s = 0;
            end else begin
                m_snz_s++;
            end
        end
        if (m_mode == 1) m_beep_cyc = (prev_mode == 1) ? m_beep_cyc + 1 : 0;
        m_match_prev = match;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("ringing", ringing, (m_mode == 1));
        check("snoozing", snoozing, (m_mode == 2));
        check("missed", missed, m_missed);
        check("buzzer", buzzer, (m_mode == 1) && (((m_beep_cyc / HALF) % 2) == 0));
    endtask

    task automatic pulse(input bit tk, input bit sn, input bit ds);
        tick_1hz = tk; snooze = sn; dismiss = ds;
        cyc();
        tick_1hz = 0; snooze = 0; dismiss = 0;
    endtask

    task automatic start_alarm();
        match = 0;
        cyc();
        match = 1;
        cyc();
    endtask

    initial begin
        bit exp_buz[5];
        exp_buz = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1;
        cyc(); cyc();
        check("rst_ringing", ringing, 0);
        check("rst_buzzer", buzzer, 0);
        rst = 0;
        cyc();

        // 1: rising match rings; held match gives no re-trigger.
        start_alarm();
        check("t1_ring", ringing, 1);
        check("t1_buz0", buzzer, exp_buz[0]);
        for (int i = 1; i < 5; i++) begin
            cyc();
            check("t1_buz_seq", buzzer, exp_buz[i]);
        end
        for (int i = 0; i < 10; i++) cyc();
        pulse(0, 0, 1);
        check("t1_dismissed", ringing, 0);
        for (int i = 0; i < 5; i++) cyc();
        check("t1_no_retrig", ringing, 0);

        // 2: timeout sets missed, dismiss clears it.
        start_alarm();
        for (int i = 0; i < RT; i++) begin
            pulse(1, 0, 0);
            cyc();
        end
        check("t2_timeout", ringing, 0);
        check("t2_missed", missed, 1);
        check("t2_buzzer", buzzer, 0);
        pulse(0, 0, 1);
        check("t2_missed_clr", missed, 0);

        // 3: snooze then resume after SNOOZE_S ticks.
        start_alarm();
        pulse(0, 1, 0);
        check("t3_snoozing", snoozing, 1);
        check("t3_buz_off", buzzer, 0);
        for (int i = 0; i < SZ; i++) pulse(1, 0, 0);
        check("t3_resume", ringing, 1);
        check("t3_buz_restart", buzzer, 1);
        pulse(0, 0, 1);
        check("t3_idle", ringing, 0);

        // 4: dismiss beats snooze; armed drop stops the ring.
        start_alarm();
        pulse(0, 1, 1);
        check("t4_dismiss_wins", snoozing, 0);
        check("t4_dismiss_ring", ringing, 0);
        start_alarm();
        armed = 0;
        cyc();
        check("t4_disarm", ringing, 0);
        armed = 1;
        cyc(); cyc();
        check("t4_no_edge", ringing, 0);

        // 5: second snooze in the same event.
        start_alarm();
        pulse(0, 1, 0);
        for (int i = 0; i < SZ; i++) pulse(1, 0, 0);
        pulse(0, 1, 0);
`ifdef ALARM_SNOOZE_LIMIT_EN
        check("t5_limit", ringing, 1);
        for (int i = 0; i < RT; i++) pulse(1, 0, 0);
        check("t5_timeout", missed, 1);
`else
        check("t5_unlimited", snoozing, 1);
`endif
        pulse(0, 0, 1);

        // 6: reset during snooze, match still high re-triggers.
        start_alarm();
        pulse(0, 1, 0);
        rst = 1;
        cyc();
        check("t6_rst_snz", snoozing, 0);
        check("t6_rst_ring", ringing, 0);
        check("t6_rst_buz", buzzer, 0);
        rst = 0;
        cyc();
        check("t6_retrig", ringing, 1);
        pulse(0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) match = ~match;
            armed    = ($urandom_range(0, 19) != 0);
            tick_1hz = ($urandom_range(0, 3) == 0);
            snooze   = ($urandom_range(0, 11) == 0);
            dismiss  = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 0; tick_1hz = 0; snooze = 0; dismiss = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
